// File: rtl/func_gen.sv
// func_gen: out = MUL_K*a +/- (floor(cbrt(b)) << CBRT_SHIFT), clamped to zero when negative.
// A shift-add multiplier and a digit-by-digit cube root run side by side, then one add/sub stage.
module func_gen #(
  parameter int W          = 8,
  parameter int MUL_K      = 3,
  parameter int CBRT_SHIFT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  input  logic         start,
  output logic [2*W:0] out,
  output logic         sat,
  output logic         busy,
  output logic         done
);

  localparam int R  = (W + 2) / 3;
  localparam int OW = 2 * W + 1;
  localparam int PW = 2 * W;
  localparam int RW = 3 * R;
  localparam int TW = 5 * R + 2;
  localparam int L  = ((W > 2 * R) ? W : 2 * R) + 1;
  localparam int CW = $clog2(L + 1);
  localparam int SW = $clog2(RW + 1);
  localparam int IW = $clog2(R + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, COMB = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   kbits_q, kbits_d;
  logic [PW-1:0]  prod_q, prod_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [R-1:0]   y_q, y_d;
  logic [TW-1:0]  t_q, t_d;
  logic [SW-1:0]  sh_q, sh_d;
  logic [IW-1:0]  rit_q, rit_d;
  logic           ph_q, ph_d;
  logic           mode_q, mode_d;
  logic [OW-1:0]  out_q, out_d;
  logic           sat_q, sat_d;
  logic           done_q, done_d;

  logic [R-1:0]   y2;
  logic [TW-1:0]  ye, t_base;
  logic [OW-1:0]  p_ext, s_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      kbits_q <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      y_q     <= '0;
      t_q     <= '0;
      sh_q    <= '0;
      rit_q   <= '0;
      ph_q    <= 1'b0;
      mode_q  <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      kbits_q <= kbits_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      y_q     <= y_d;
      t_q     <= t_d;
      sh_q    <= sh_d;
      rit_q   <= rit_d;
      ph_q    <= ph_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(L - 2)) state_d = COMB;
      COMB:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  always_comb begin
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    kbits_d = kbits_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    y_d     = y_q;
    t_d     = t_q;
    sh_d    = sh_q;
    rit_d   = rit_q;
    ph_d    = ph_q;
    mode_d  = mode_q;
    out_d   = out_q;
    sat_d   = sat_q;
    done_d  = 1'b0;

    // Trial subtrahend for the next root bit, formed from the already-doubled y.
    y2     = y_q << 1;
    ye     = TW'(y2);
    t_base = (ye + ye + ye) * (ye + TW'(1)) + TW'(1);
    p_ext  = OW'(prod_q);
    s_ext  = OW'(y_q) << CBRT_SHIFT;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          mcand_d = PW'(a);
          kbits_d = W'(MUL_K);
          prod_d  = '0;
          rem_d   = RW'(b);
          y_d     = '0;
          t_d     = '0;
          sh_d    = SW'(3 * (R - 1));
          rit_d   = IW'(R);
          ph_d    = 1'b0;
          mode_d  = mode;
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        // Constant bits are consumed LSB first; once exhausted the product simply holds.
        if (kbits_q[0]) prod_d = prod_q + mcand_q;
        mcand_d = mcand_q << 1;
        kbits_d = kbits_q >> 1;
        if (rit_q != '0) begin
          if (!ph_q) begin
            y_d  = y2;
            t_d  = t_base << sh_q;
            ph_d = 1'b1;
          end else begin
            if (TW'(rem_q) >= t_q) begin
              rem_d = rem_q - RW'(t_q);
              y_d   = y_q + R'(1);
            end
            ph_d  = 1'b0;
            rit_d = rit_q - IW'(1);
            sh_d  = sh_q - SW'(3);
          end
        end
      end
      COMB: begin
        done_d = 1'b1;
        if (!mode_q) begin
          out_d = p_ext + s_ext;
          sat_d = 1'b0;
        end else if (p_ext >= s_ext) begin
          out_d = p_ext - s_ext;
          sat_d = 1'b0;
        end else begin
          out_d = '0;
          sat_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out  = out_q;
  assign sat  = sat_q;
  assign done = done_q;

endmodule

// File: tb/tb_func_gen.sv
// Randomised and directed bench for func_gen against a countdown/arithmetic reference model.
module tb_func_gen;
  localparam int W  = 8;
  localparam int K  = 3;
  localparam int S  = 1;
  localparam int L  = 9;
  localparam int OW = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          mode = 1'b0;
  logic          start = 1'b0;
  logic [OW-1:0] out;
  logic          sat, busy, done;

  int checks = 0;
  int errors = 0;

  func_gen #(.W(W), .MUL_K(K), .CBRT_SHIFT(S)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .start(start),
    .out(out), .sat(sat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int icbrt(input int v);
    int r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
    return r;
  endfunction

  function automatic longint ref_diff(input int av, input int bv, input bit md);
    longint p = longint'(av) * K;
    longint s = longint'(icbrt(bv)) << S;
    return md ? p - s : p + s;
  endfunction

  function automatic logic [OW-1:0] ref_out(input int av, input int bv, input bit md);
    longint d = ref_diff(av, bv, md);
    return (d < 0) ? '0 : OW'(d);
  endfunction

  function automatic bit ref_sat(input int av, input int bv, input bit md);
    return ref_diff(av, bv, md) < 0;
  endfunction

  // Reference model: an accepted request completes exactly L edges later.
  int            m_cnt = 0;
  logic [OW-1:0] m_out = '0;
  logic          m_sat = 1'b0;
  logic          m_done = 1'b0;
  logic [W-1:0]  la = '0, lb = '0;
  logic          lm = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt  <= 0;
      m_out  <= '0;
      m_sat  <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          la    <= a;
          lb    <= b;
          lm    <= mode;
          m_cnt <= L;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_out  <= ref_out(int'(la), int'(lb), lm);
          m_sat  <= ref_sat(int'(la), int'(lb), lm);
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (out !== m_out || sat !== m_sat || busy !== (m_cnt != 0) || done !== m_done) begin
      errors++;
      $display("FAIL cycle t=%0t out=%0d/%0d sat=%0b/%0b busy=%0b/%0b done=%0b/%0b",
               $time, out, m_out, sat, m_sat, busy, (m_cnt != 0), done, m_done);
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s = %0d", nm, act);
    end
  endtask

  task automatic run_op(input int av, input int bv, input bit md, input int pulse_at,
                        input int exp_out, input bit exp_sat, input string nm);
    int k;
    bit found;
    @(negedge clk);
    a = W'(av); b = W'(bv); mode = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
    k = 1;
    found = 1'b0;
    while (!found && k <= 30) begin
      if (done) found = 1'b1;
      else begin
        start = (k == pulse_at);
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    chk({nm, "_found"}, found, 1);
    chk({nm, "_lat"}, k, L + 1);
    chk({nm, "_out"}, out, exp_out);
    chk({nm, "_sat"}, sat, exp_sat);
    @(negedge clk);
    chk({nm, "_done_fall"}, done, 0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  initial begin
    int prev, ndone, nd;

    chk("model_basic", ref_out(10, 27, 1'b0), 36);
    chk("model_max", ref_out(255, 255, 1'b0), 777);
    chk("model_sub", ref_out(5, 8, 1'b1), 11);
    chk("model_clamp_sat", ref_sat(0, 64, 1'b1), 1);
    chk("model_small", ref_out(1, 1, 1'b0), 5);

    repeat (2) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sat", sat, 0);
    rst = 1'b1;

    run_op(10, 27, 1'b0, 0, 36, 1'b0, "basic");
    run_op(255, 255, 1'b0, 0, 777, 1'b0, "max");
    run_op(0, 0, 1'b0, 0, 0, 1'b0, "zero");
    run_op(5, 8, 1'b1, 0, 11, 1'b0, "sub");
    run_op(0, 64, 1'b1, 0, 0, 1'b1, "clamp");
    run_op(1, 1, 1'b0, 0, 5, 1'b0, "after_clamp");
    run_op(10, 27, 1'b0, 3, 36, 1'b0, "ignored_start");

    // start held high: back-to-back completions every L+1 edges
    @(negedge clk);
    a = 8'd2; b = 8'd1; mode = 1'b0; start = 1'b1;
    prev = -1;
    ndone = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("hold_out", out, 8);
        if (prev >= 0) chk("hold_spacing", k - prev, L + 1);
        prev = k;
      end
    end
    chk("hold_count", ndone, 4);
    start = 1'b0;
    wait_idle("hold");

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    a = 8'd10; b = 8'd27; mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("rst_out", out, 0);
    chk("rst_sat", sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", nd, 0);
    run_op(10, 27, 1'b0, 0, 36, 1'b0, "post_rst");

    // random traffic, including starts while busy and boundary operands
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      case ($urandom % 4)
        0: a = 8'd0;
        1: a = 8'd255;
        default: a = W'($urandom);
      endcase
      case ($urandom % 4)
        0: b = 8'd0;
        1: b = 8'd255;
        default: b = W'($urandom);
      endcase
      mode  = 1'($urandom);
      start = (($urandom % 3) == 0);
    end
    start = 1'b0;
    wait_idle("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
